// File: rtl/gesturespeak_pkg.sv
// Shared types and defaults for the gesture hold/speak path.
package gesturespeak_pkg;

    localparam int GESTURE_W_DEF  = 4;
    localparam int IDLE_CODE_DEF  = 0;
    localparam int HOLD_TICKS_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_TRACK        = 2'd1,
        ST_EMIT         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } ghv_state_e;

endpackage

// File: rtl/gesture_hold_validator_tick_edge_detect.sv
// Rising-edge detector for a slow same-domain level (e.g. a divided clock).
// History resets to 1 so a level already high at reset release is not an edge.
module tick_edge_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_d;

    // one-cycle history of the level
    always_ff @(posedge clk_in) begin
        if (rst) level_d <= 1'b1;
        else     level_d <= level;
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/gesture_hold_validator.sv
// Gesture hold validator: emits one speak request once a non-idle gesture
// code has stayed stable over HOLD_TICKS divided-clock rising edges.
// Optional macro GESTURE_REPEAT_EN: auto-repeat while the gesture stays held.
module gesture_hold_validator
    import gesturespeak_pkg::*;
#(
    parameter int GESTURE_W  = GESTURE_W_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF,
    parameter int IDLE_CODE  = IDLE_CODE_DEF
) (
    input  logic                               clk_in,
    input  logic                               rst,
    input  logic                               tick_clk,
    input  logic                               gesture_valid,
    input  logic [GESTURE_W-1:0]               gesture_code,
    output logic                               speak_valid,
    output logic [GESTURE_W-1:0]               speak_code,
    input  logic                               speak_ready,
    output logic                               busy,
    output logic [$clog2(HOLD_TICKS+1)-1:0]    hold_count
);

    localparam int                    CNT_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0]      HOLD_MAX = CNT_W'(HOLD_TICKS);
    localparam logic [GESTURE_W-1:0]  IDLE_C   = GESTURE_W'(IDLE_CODE);

    ghv_state_e            state_q, state_n;
    logic [GESTURE_W-1:0]  cand_q, cand_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n, cnt_inc;
    logic                  sv_q, sv_n;
    logic [GESTURE_W-1:0]  sc_q, sc_n;
    logic                  tick, new_code, match;

    tick_edge_detect u_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .level  (tick_clk),
        .rise   (tick)
    );

    assign new_code = gesture_valid && (gesture_code != IDLE_C);
    assign match    = new_code && (gesture_code == cand_q);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // state and datapath registers; reset overrides a pending request
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            sv_q    <= 1'b0;
            sc_q    <= '0;
        end else begin
            state_q <= state_n;
            cand_q  <= cand_n;
            cnt_q   <= cnt_n;
            sv_q    <= sv_n;
            sc_q    <= sc_n;
        end
    end

    // next-state: a code change always beats a coincident tick; the count
    // only advances while below HOLD_MAX, so it saturates and never wraps
    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        cnt_n   = cnt_q;
        sv_n    = sv_q;
        sc_n    = sc_q;
        case (state_q)
            ST_IDLE: begin
                if (new_code) begin
                    cand_n  = gesture_code;
                    cnt_n   = '0;
                    state_n = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!match) begin
                    cnt_n = '0;
                    if (new_code) cand_n  = gesture_code;
                    else          state_n = ST_IDLE;
                end else if (tick) begin
                    if (cnt_inc >= HOLD_MAX) begin
                        cnt_n   = HOLD_MAX;
                        sv_n    = 1'b1;
                        sc_n    = cand_q;
                        state_n = ST_EMIT;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            ST_EMIT: begin
                // gesture inputs ignored; wait for the handshake, no timeout
                if (sv_q && speak_ready) begin
                    sv_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!match) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end
`ifdef GESTURE_REPEAT_EN
                else if (tick) begin
                    if (cnt_inc >= HOLD_MAX) begin
                        cnt_n   = HOLD_MAX;
                        sv_n    = 1'b1;
                        sc_n    = cand_q;
                        state_n = ST_EMIT;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign speak_valid = sv_q;
    assign speak_code  = sc_q;
    assign busy        = (state_q != ST_IDLE);
    assign hold_count  = cnt_q;

endmodule

// File: tb/tb_gesture_hold_validator.sv
// Vector-table bench for gesture_hold_validator (HOLD_TICKS=2, GESTURE_W=4,
// IDLE_CODE=0). Each vector is held for n cycles; expected outputs are
// queued when a cycle is driven and compared after the clock edge.
module tb_gesture_hold_validator;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tick_clk = 1'b1;
    logic       gesture_valid = 1'b0;
    logic [3:0] gesture_code = 4'd0;
    logic       speak_ready = 1'b0;
    logic       speak_valid;
    logic [3:0] speak_code;
    logic       busy;
    logic [1:0] hold_count;

    gesture_hold_validator #(
        .GESTURE_W  (4),
        .HOLD_TICKS (2),
        .IDLE_CODE  (0)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .tick_clk      (tick_clk),
        .gesture_valid (gesture_valid),
        .gesture_code  (gesture_code),
        .speak_valid   (speak_valid),
        .speak_code    (speak_code),
        .speak_ready   (speak_ready),
        .busy          (busy),
        .hold_count    (hold_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         n;
        int         sec;
        logic       rst;
        logic       tk;
        logic       gv;
        logic [3:0] code;
        logic       rdy;
        logic       sv;
        logic [3:0] sc;
        logic       busy;
        logic [1:0] hc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int n, input int sec, input logic r, input logic tk,
                                input logic gv, input logic [3:0] code, input logic rdy,
                                input logic sv, input logic [3:0] sc, input logic bz,
                                input logic [1:0] hc);
        vec_t v;
        v.n = n; v.sec = sec; v.rst = r; v.tk = tk; v.gv = gv; v.code = code; v.rdy = rdy;
        v.sv = sv; v.sc = sc; v.busy = bz; v.hc = hc;
        return v;
    endfunction

    task automatic run(input vec_t v);
        vec_t e;
        for (int i = 0; i < v.n; i++) begin
            rst           = v.rst;
            tick_clk      = v.tk;
            gesture_valid = v.gv;
            gesture_code  = v.code;
            speak_ready   = v.rdy;
            exp_q.push_back(v);
            @(posedge clk_in);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if (speak_valid !== e.sv || speak_code !== e.sc || busy !== e.busy ||
                hold_count !== e.hc) begin
                n_err++;
                $display("FAIL sec%0d cyc%0d: got sv=%b sc=%0d busy=%b hc=%0d, need sv=%b sc=%0d busy=%b hc=%0d",
                         e.sec, i, speak_valid, speak_code, busy, hold_count,
                         e.sv, e.sc, e.busy, e.hc);
            end
        end
    endtask

    initial begin
        // ---- table: reset, basic emit, candidate change, tick/change collision
        //            n  sec rst tk gv code rdy  sv sc busy hc
        // reset with tick_clk high, then release with it still high
        tbl.push_back(mk( 3, 1, 1, 1, 1, 4'd5, 0,  0, 4'd0, 0, 2'd0));
        tbl.push_back(mk( 3, 1, 0, 1, 1, 4'd5, 0,  0, 4'd0, 1, 2'd0));
        tbl.push_back(mk(10, 1, 0, 0, 1, 4'd5, 0,  0, 4'd0, 1, 2'd0));
        // basic emit: two tick edges on code 5
        tbl.push_back(mk( 1, 2, 0, 1, 1, 4'd5, 0,  0, 4'd0, 1, 2'd1));
        tbl.push_back(mk( 9, 2, 0, 1, 1, 4'd5, 0,  0, 4'd0, 1, 2'd1));
        tbl.push_back(mk(10, 2, 0, 0, 1, 4'd5, 0,  0, 4'd0, 1, 2'd1));
        tbl.push_back(mk( 1, 2, 0, 1, 1, 4'd5, 0,  1, 4'd5, 1, 2'd2));
        // ready low: request stable even if the gesture input changes
        tbl.push_back(mk( 9, 2, 0, 1, 1, 4'd9, 0,  1, 4'd5, 1, 2'd2));
        tbl.push_back(mk( 1, 2, 0, 0, 1, 4'd5, 0,  1, 4'd5, 1, 2'd2));
        tbl.push_back(mk( 1, 2, 0, 0, 1, 4'd5, 1,  0, 4'd5, 1, 2'd0));
        tbl.push_back(mk( 8, 2, 0, 0, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
        // release, then ready with nothing pending
        tbl.push_back(mk( 2, 3, 0, 0, 0, 4'd0, 0,  0, 4'd5, 0, 2'd0));
        tbl.push_back(mk( 3, 3, 0, 0, 0, 4'd0, 1,  0, 4'd5, 0, 2'd0));
        // candidate change: 5 for one tick, then 6
        tbl.push_back(mk( 1, 4, 0, 0, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
        tbl.push_back(mk( 9, 4, 0, 0, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
        tbl.push_back(mk( 1, 4, 0, 1, 1, 4'd5, 0,  0, 4'd5, 1, 2'd1));
        tbl.push_back(mk( 9, 4, 0, 1, 1, 4'd5, 0,  0, 4'd5, 1, 2'd1));
        tbl.push_back(mk( 1, 4, 0, 0, 1, 4'd6, 0,  0, 4'd5, 1, 2'd0));
        tbl.push_back(mk( 9, 4, 0, 0, 1, 4'd6, 0,  0, 4'd5, 1, 2'd0));
        tbl.push_back(mk( 1, 4, 0, 1, 1, 4'd6, 0,  0, 4'd5, 1, 2'd1));
        tbl.push_back(mk( 9, 4, 0, 1, 1, 4'd6, 0,  0, 4'd5, 1, 2'd1));
        tbl.push_back(mk(10, 4, 0, 0, 1, 4'd6, 0,  0, 4'd5, 1, 2'd1));
        tbl.push_back(mk( 1, 4, 0, 1, 1, 4'd6, 0,  1, 4'd6, 1, 2'd2));
        tbl.push_back(mk( 1, 4, 0, 1, 1, 4'd6, 1,  0, 4'd6, 1, 2'd0));
        tbl.push_back(mk( 8, 4, 0, 1, 0, 4'd0, 0,  0, 4'd6, 0, 2'd0));
        tbl.push_back(mk(10, 4, 0, 0, 0, 4'd0, 0,  0, 4'd6, 0, 2'd0));
        // collision: 5 credited one tick, then changes to 7 in a tick cycle
        tbl.push_back(mk(10, 5, 0, 0, 1, 4'd5, 0,  0, 4'd6, 1, 2'd0));
        tbl.push_back(mk( 1, 5, 0, 1, 1, 4'd5, 0,  0, 4'd6, 1, 2'd1));
        tbl.push_back(mk( 9, 5, 0, 1, 1, 4'd5, 0,  0, 4'd6, 1, 2'd1));
        tbl.push_back(mk(10, 5, 0, 0, 1, 4'd5, 0,  0, 4'd6, 1, 2'd1));
        tbl.push_back(mk( 1, 5, 0, 1, 1, 4'd7, 0,  0, 4'd6, 1, 2'd0));
        tbl.push_back(mk( 9, 5, 0, 1, 1, 4'd7, 0,  0, 4'd6, 1, 2'd0));
        tbl.push_back(mk(10, 5, 0, 0, 1, 4'd7, 0,  0, 4'd6, 1, 2'd0));
        tbl.push_back(mk( 1, 5, 0, 1, 1, 4'd7, 0,  0, 4'd6, 1, 2'd1));
        tbl.push_back(mk( 9, 5, 0, 1, 1, 4'd7, 0,  0, 4'd6, 1, 2'd1));
        tbl.push_back(mk(10, 5, 0, 0, 1, 4'd7, 0,  0, 4'd6, 1, 2'd1));
        tbl.push_back(mk( 1, 5, 0, 1, 1, 4'd7, 0,  1, 4'd7, 1, 2'd2));
        tbl.push_back(mk( 5, 5, 0, 1, 1, 4'd7, 0,  1, 4'd7, 1, 2'd2));

        foreach (tbl[k]) run(tbl[k]);

        // ---- reset mid-EMIT, then IDLE_CODE input keeps the block idle
        run(mk(1, 6, 1, 1, 1, 4'd7, 0,  0, 4'd0, 0, 2'd0));
        run(mk(9, 6, 0, 0, 1, 4'd0, 0,  0, 4'd0, 0, 2'd0));
        run(mk(1, 6, 0, 1, 1, 4'd0, 0,  0, 4'd0, 0, 2'd0));
        run(mk(9, 6, 0, 1, 1, 4'd0, 0,  0, 4'd0, 0, 2'd0));
        // IDLE_CODE while tracking drops back to idle
        run(mk(1, 6, 0, 0, 1, 4'd3, 0,  0, 4'd0, 1, 2'd0));
        run(mk(1, 6, 0, 0, 1, 4'd0, 0,  0, 4'd0, 0, 2'd0));
        run(mk(8, 6, 0, 0, 0, 4'd0, 0,  0, 4'd0, 0, 2'd0));

        // ---- hold after emit: emit code 5, transfer, then keep holding 6 ticks
        run(mk(10, 7, 0, 0, 1, 4'd5, 0,  0, 4'd0, 1, 2'd0));
        run(mk( 1, 7, 0, 1, 1, 4'd5, 0,  0, 4'd0, 1, 2'd1));
        run(mk( 9, 7, 0, 1, 1, 4'd5, 0,  0, 4'd0, 1, 2'd1));
        run(mk(10, 7, 0, 0, 1, 4'd5, 0,  0, 4'd0, 1, 2'd1));
        run(mk( 1, 7, 0, 1, 1, 4'd5, 0,  1, 4'd5, 1, 2'd2));
        run(mk( 1, 7, 0, 1, 1, 4'd5, 1,  0, 4'd5, 1, 2'd0));
        run(mk( 8, 7, 0, 1, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
        run(mk(10, 7, 0, 0, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
`ifdef GESTURE_REPEAT_EN
        // second request after two more ticks, count restarts after transfer
        run(mk( 1, 8, 0, 1, 1, 4'd5, 0,  0, 4'd5, 1, 2'd1));
        run(mk( 9, 8, 0, 1, 1, 4'd5, 0,  0, 4'd5, 1, 2'd1));
        run(mk(10, 8, 0, 0, 1, 4'd5, 0,  0, 4'd5, 1, 2'd1));
        run(mk( 1, 8, 0, 1, 1, 4'd5, 0,  1, 4'd5, 1, 2'd2));
        run(mk( 9, 8, 0, 1, 1, 4'd5, 0,  1, 4'd5, 1, 2'd2));
        run(mk( 1, 8, 0, 0, 1, 4'd5, 1,  0, 4'd5, 1, 2'd0));
        run(mk( 9, 8, 0, 0, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
`else
        // single emission per hold: no request over six further ticks
        for (int p = 0; p < 6; p++) begin
            run(mk( 1, 8, 0, 1, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
            run(mk( 9, 8, 0, 1, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
            run(mk(10, 8, 0, 0, 1, 4'd5, 0,  0, 4'd5, 1, 2'd0));
        end
`endif
        run(mk(3, 8, 0, 0, 0, 4'd0, 0,  0, 4'd5, 0, 2'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gesture_hold_validator.md
# gesture_hold_validator

Downstream consumer of the board's divided ~1 Hz clock. It samples the recognised gesture code and counts divided-clock rising edges while the code stays stable. Once a non-idle gesture has been held for HOLD_TICKS edges, it issues one speak request to the speech/output stage over a valid/ready handshake. Everything runs in the 50 MHz domain; the divided clock is used only as a sampled enable, never as a clock.

## Interface
- GESTURE_W, 4: gesture code width
- HOLD_TICKS, 2: rising edges of tick_clk a code must stay stable before emission; ≥1
- IDLE_CODE, 0: code meaning "no gesture"; never emitted
- clk_in  in  1  50 MHz board clock; the only clock
- rst  in  1  synchronous, active-high reset
- tick_clk  in  1  divided clock from the divider; same-domain level signal
- gesture_valid  in  1  gesture_code is meaningful this cycle
- gesture_code  in  GESTURE_W  current recognised gesture
- speak_valid  out  1  speak request pending
- speak_code  out  GESTURE_W  gesture to speak; stable while speak_valid=1
- speak_ready  in  1  downstream accepts; transfer when speak_valid & speak_ready
- busy  out  1  FSM not in IDLE
- hold_count  out  $clog2(HOLD_TICKS+1)  ticks accumulated on current candidate

## Operation
- Edge detect: tick_d registers tick_clk. Tick cycle = tick_clk & ~tick_d.
- Match = gesture_valid & (gesture_code == cand) & (gesture_code != IDLE_CODE).
- FSM states: IDLE, TRACK, EMIT, WAIT_RELEASE.
- IDLE: on gesture_valid & code != IDLE_CODE, capture cand, clear hold_count, go to TRACK. A tick in the capture cycle is not counted.
- TRACK, !match:
  - If a new valid non-idle code is present, recapture it, clear hold_count, stay in TRACK.
  - Otherwise go to IDLE.
- TRACK, match & tick: hold_count+1. When it reaches HOLD_TICKS, load speak_code=cand, set speak_valid, go to EMIT.
- Simultaneous tick and code change: the change wins and the tick is discarded.
- EMIT:
  - Hold speak_valid and speak_code; ignore gesture inputs.
  - On transfer, clear speak_valid and go to WAIT_RELEASE.
  - No timeout.
- WAIT_RELEASE: on !match, go to IDLE. While the gesture is held, no further emission (see Configuration).
- hold_count saturates at HOLD_TICKS and never wraps.

## Timing
- Reset values: speak_valid=0, speak_code=0, busy=0, hold_count=0, state=IDLE, cand=0, tick_d=1. tick_d=1 means a tick_clk already high at reset release is not counted.
- Reset is synchronous: it takes effect at the first clk_in edge with rst=1 and overrides everything, including a pending EMIT.
- Emission latency: speak_valid rises on the clk_in edge that ends the HOLD_TICKS-th tick cycle, i.e. visible the cycle after that tick cycle.
- speak_valid falls on the clk_in edge where speak_valid & speak_ready is sampled.
- Back-to-back emission minimum: EMIT→WAIT_RELEASE→IDLE→TRACK, plus HOLD_TICKS ticks.
- speak_ready while speak_valid=0 has no effect.

## Configuration
- GESTURE_REPEAT_EN defined: in WAIT_RELEASE, while match holds, hold_count counts ticks again. Reaching HOLD_TICKS re-emits cand (to EMIT) and restarts the count, giving auto-repeat of a held gesture.
- GESTURE_REPEAT_EN undefined: WAIT_RELEASE never counts; exactly one emission per continuous hold.

## Structure
- gesturespeak_pkg holds:
  - FSM state enum
  - IDLE_CODE default constant
  - GESTURE_W default
- Sub-module tick_edge_detect: clk_in, rst, level in, rise out. Registered-history rising-edge detector, reset history 1. Reusable by other divided-clock consumers.

## Test plan
All scenarios use HOLD_TICKS=2, GESTURE_W=4, IDLE_CODE=0. The bench drives tick_clk directly with a 20-cycle period.
- Reset: rst=1 for 3 cycles with tick_clk=1, then release with tick_clk still 1 and code 5 valid → no tick counted until the next low→high transition; all outputs 0 during reset.
- Basic emit: code 5 held over 2 tick edges → speak_valid=1, speak_code=5 the cycle after the 2nd tick cycle. Hold speak_ready=0 for 10 cycles → outputs stable. Assert ready → speak_valid=0 next cycle.
- Candidate change: code 5 for 1 tick, then code 6 → hold_count=0 on the change; emission is code 6 after 2 ticks of 6; code 5 is never emitted.
- Tick/change collision: code changes 5→7 in a tick cycle → hold_count=0 afterwards, and that tick is not credited to 7.
- Hold after emit: code 5 held for 6 ticks after transfer → no second request with the macro off. With GESTURE_REPEAT_EN, a second code-5 request appears after 2 more ticks.
- Reset mid-EMIT: rst=1 while speak_valid=1 → speak_valid=0, busy=0 on the next edge; IDLE_CODE input after release keeps the block in IDLE.
